// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - transaction-locked arbiter sharing the SPI RAM between port A and port B
// Optional feature macro: ARB_RR_EN (round-robin arbitration; fixed A-over-B priority when undefined).
// Ports:
//   clk, rst_n                clock (rising edge), synchronous active-low reset
//   a_din, a_valid            port-A command words, no backpressure, buffered in a small FIFO
//   a_dout, a_dout_valid      read data returned to port A
//   a_overflow                sticky flag: a port-A word was dropped on a full FIFO
//   b_din, b_valid, b_ready   port-B command handshake
//   b_dout, b_dout_valid      read data returned to port B
//   ram_din, ram_valid        command word forwarded to the RAM
//   ram_dout, ram_dout_valid  RAM read data
//   lock_timeout              1-cycle pulse when a stalled lock is forcibly released
module spi_ram_arbiter #(
  parameter int A_FIFO_DEPTH = 2,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] a_din,
  input  logic       a_valid,
  output logic [7:0] a_dout,
  output logic       a_dout_valid,
  output logic       a_overflow,
  input  logic [9:0] b_din,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] b_dout,
  output logic       b_dout_valid,
  output logic [9:0] ram_din,
  output logic       ram_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_dout_valid,
  output logic       lock_timeout
);

  localparam int PW = (A_FIFO_DEPTH > 1) ? $clog2(A_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WDATA = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, WAIT_RD} state_t;

  state_t        state, state_next;
  logic          owner_b;
  logic [CW-1:0] tmo_cnt;
  logic          a_first;

  logic [9:0]    fifo_mem [A_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop;

  logic          acc;
  logic          acc_b;
  logic [9:0]    acc_word;
  logic          timeout_hit;

  // Port-A command buffer. A pop in the same cycle frees a slot, so a push
  // into a full FIFO is only dropped when nothing is leaving.
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PW + 1)'(A_FIFO_DEPTH));
  assign fifo_push  = a_valid && (!fifo_full || fifo_pop);

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= a_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      a_overflow <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
      if (a_valid && fifo_full && !fifo_pop) a_overflow <= 1'b1;
    end
  end

  // Arbitration, word acceptance and lock transitions.
  always_comb begin
    state_next  = state;
    fifo_pop    = 1'b0;
    b_ready     = 1'b0;
    acc         = 1'b0;
    acc_b       = 1'b0;
    acc_word    = fifo_mem[rd_ptr];
    timeout_hit = 1'b0;

    if (rst_n) begin
      case (state)
        IDLE: begin
          if (!fifo_empty && (a_first || !b_valid)) begin
            fifo_pop = 1'b1;
            acc      = 1'b1;
          end else if (b_valid) begin
            b_ready  = 1'b1;
            acc      = 1'b1;
            acc_b    = 1'b1;
            acc_word = b_din;
          end
        end
        OWN_A: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            acc      = 1'b1;
          end
        end
        OWN_B: begin
          b_ready = 1'b1;
          if (b_valid) begin
            acc      = 1'b1;
            acc_b    = 1'b1;
            acc_word = b_din;
          end
        end
        default: ;
      endcase

      // Any accepted command re-targets the lock, so a mismatched command
      // simply acts as a re-address rather than an error.
      if (acc) begin
        case (acc_word[9:8])
          CMD_WADDR, CMD_RADDR: state_next = acc_b ? OWN_B : OWN_A;
          CMD_WDATA:            state_next = IDLE;
          default:              state_next = WAIT_RD;
        endcase
      end else if (state == WAIT_RD && ram_dout_valid) begin
        state_next = IDLE;
      end else if (state != IDLE && tmo_cnt == CW'(LOCK_TIMEOUT - 1)) begin
        state_next  = IDLE;
        timeout_hit = 1'b1;
      end
    end
  end

`ifdef ARB_RR_EN
  // Remembers who released last so that a tie in IDLE goes to the other port.
  logic last_owner_b;
  logic releasing;

  assign a_first   = last_owner_b;
  assign releasing = (state_next == IDLE) && ((state != IDLE) || acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_owner_b <= 1'b1;
    end else if (releasing) begin
      last_owner_b <= (state == IDLE) ? acc_b : owner_b;
    end
  end
`else
  assign a_first = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner_b      <= 1'b0;
      tmo_cnt      <= '0;
      ram_din      <= '0;
      ram_valid    <= 1'b0;
      a_dout       <= '0;
      a_dout_valid <= 1'b0;
      b_dout       <= '0;
      b_dout_valid <= 1'b0;
      lock_timeout <= 1'b0;
    end else begin
      state        <= state_next;
      ram_valid    <= acc;
      lock_timeout <= timeout_hit;
      a_dout_valid <= 1'b0;
      b_dout_valid <= 1'b0;

      if (acc) begin
        ram_din <= acc_word;
        owner_b <= acc_b;
      end

      // Counts cycles the lock owner leaves the RAM idle.
      if (acc || state_next == IDLE) begin
        tmo_cnt <= '0;
      end else if (state != IDLE) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      // Read data is only meaningful to the port that issued the read.
      if (state == WAIT_RD && ram_dout_valid) begin
        if (owner_b) begin
          b_dout       <= ram_dout;
          b_dout_valid <= 1'b1;
        end else begin
          a_dout       <= ram_dout;
          a_dout_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - directed self-checking bench for spi_ram_arbiter with a behavioural RAM
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] a_din = '0;
  logic       a_valid = 1'b0;
  logic [7:0] a_dout;
  logic       a_dout_valid;
  logic       a_overflow;
  logic [9:0] b_din = '0;
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [7:0] b_dout;
  logic       b_dout_valid;
  logic [9:0] ram_din;
  logic       ram_valid;
  logic [7:0] ram_dout = '0;
  logic       ram_dout_valid = 1'b0;
  logic       lock_timeout;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.A_FIFO_DEPTH(2), .LOCK_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_din(a_din), .a_valid(a_valid), .a_dout(a_dout), .a_dout_valid(a_dout_valid),
    .a_overflow(a_overflow),
    .b_din(b_din), .b_valid(b_valid), .b_ready(b_ready), .b_dout(b_dout),
    .b_dout_valid(b_dout_valid),
    .ram_din(ram_din), .ram_valid(ram_valid), .ram_dout(ram_dout),
    .ram_dout_valid(ram_dout_valid), .lock_timeout(lock_timeout)
  );

  // RAM with one shared address latch; read data one cycle after a read-data command.
  logic [7:0] mem [256];
  logic [7:0] ram_addr = '0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
  end

  always @(posedge clk) begin
    ram_dout_valid <= 1'b0;
    if (ram_valid) begin
      case (ram_din[9:8])
        2'b00, 2'b10: ram_addr <= ram_din[7:0];
        2'b01:        mem[ram_addr] <= ram_din[7:0];
        default: begin
          ram_dout       <= mem[ram_addr];
          ram_dout_valid <= 1'b1;
        end
      endcase
    end
  end

  logic [9:0] fwd [$];
  always @(negedge clk) if (ram_valid) fwd.push_back(ram_din);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({a_dout, a_dout_valid, a_overflow, b_dout, b_dout_valid, b_ready, ram_din, ram_valid, lock_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: a_dout=%h a_dv=%b a_ovf=%b b_dout=%h b_dv=%b b_ready=%b ram_din=%h ram_valid=%b lock_timeout=%b, expected all 0",
               a_dout, a_dout_valid, a_overflow, b_dout, b_dout_valid, b_ready, ram_din, ram_valid, lock_timeout);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_a_write();
    fwd.delete();
    a_din = 10'h012; a_valid = 1'b1; step();
    a_din = 10'h1A5; step();
    n_checks++;
    if (!(ram_valid === 1'b1 && ram_din === 10'h012)) begin
      n_fail++; $display("FAIL a_write_addr: ram_valid=%b ram_din=%h, expected 1 / 012", ram_valid, ram_din);
    end
    a_valid = 1'b0; step();
    n_checks++;
    if (!(ram_valid === 1'b1 && ram_din === 10'h1A5)) begin
      n_fail++; $display("FAIL a_write_data: ram_valid=%b ram_din=%h, expected 1 / 1a5", ram_valid, ram_din);
    end
    step();
    n_checks++;
    if (mem[8'h12] !== 8'hA5 || ram_valid !== 1'b0) begin
      n_fail++; $display("FAIL a_write_ram: mem[12]=%h ram_valid=%b, expected a5 / 0", mem[8'h12], ram_valid);
    end
  endtask

  task automatic test_b_read();
    b_din = 10'h212; b_valid = 1'b1; #1;
    n_checks++;
    if (b_ready !== 1'b1) begin n_fail++; $display("FAIL b_read_idle_ready: b_ready=%b, expected 1", b_ready); end
    step();
    n_checks++;
    if (!(ram_valid === 1'b1 && ram_din === 10'h212)) begin
      n_fail++; $display("FAIL b_read_addr: ram_valid=%b ram_din=%h, expected 1 / 212", ram_valid, ram_din);
    end
    b_din = 10'h300; #1;
    n_checks++;
    if (b_ready !== 1'b1) begin n_fail++; $display("FAIL b_read_own_ready: b_ready=%b, expected 1", b_ready); end
    step();
    n_checks++;
    if (!(ram_valid === 1'b1 && ram_din === 10'h300)) begin
      n_fail++; $display("FAIL b_read_cmd: ram_valid=%b ram_din=%h, expected 1 / 300", ram_valid, ram_din);
    end
    b_din = 10'h012; #1;
    n_checks++;
    if (b_ready !== 1'b0) begin n_fail++; $display("FAIL b_read_wait_ready: b_ready=%b, expected 0", b_ready); end
    step();
    n_checks++;
    if (b_ready !== 1'b0 || b_dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL b_read_wait_hold: b_ready=%b b_dout_valid=%b, expected 0 / 0", b_ready, b_dout_valid);
    end
    step();
    b_valid = 1'b0;
    n_checks++;
    if (!(b_dout_valid === 1'b1 && b_dout === 8'hA5)) begin
      n_fail++; $display("FAIL b_read_data: b_dout_valid=%b b_dout=%h, expected 1 / a5", b_dout_valid, b_dout);
    end
    step();
    n_checks++;
    if (b_dout_valid !== 1'b0 || ram_valid !== 1'b0) begin
      n_fail++; $display("FAIL b_read_pulse: b_dout_valid=%b ram_valid=%b, expected 0 / 0", b_dout_valid, ram_valid);
    end
  endtask

  task automatic test_lock_hold();
    bit got;
    fwd.delete();
    b_din = 10'h240; b_valid = 1'b1; step(); b_valid = 1'b0;
    a_din = 10'h001; a_valid = 1'b1; step(); a_valid = 1'b0;
    repeat (19) step();
    n_checks++;
    if (fwd.size() != 1 || fwd[0] !== 10'h240) begin
      n_fail++; $display("FAIL lock_hold_blocked: forwarded %0d words (first %h), expected 1 word 240", fwd.size(), fwd[0]);
    end
    b_din = 10'h300; b_valid = 1'b1; step(); b_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin step(); if (b_dout_valid) got = 1'b1; end
    n_checks++;
    if (!(got && b_dout === 8'h1A)) begin
      n_fail++; $display("FAIL lock_hold_read: got=%b b_dout=%h, expected 1 / 1a", got, b_dout);
    end
    repeat (3) step();
    n_checks++;
    if (fwd.size() != 3 || fwd[1] !== 10'h300 || fwd[2] !== 10'h001) begin
      n_fail++; $display("FAIL lock_hold_release: size=%0d w1=%h w2=%h, expected 3 / 300 / 001", fwd.size(), fwd[1], fwd[2]);
    end
    a_din = 10'h1FF; a_valid = 1'b1; step(); a_valid = 1'b0;
    repeat (3) step();
    n_checks++;
    if (fwd.size() != 4 || fwd[3] !== 10'h1FF || mem[8'h01] !== 8'hFF) begin
      n_fail++; $display("FAIL lock_hold_a_write: size=%0d w3=%h mem[01]=%h, expected 4 / 1ff / ff", fwd.size(), fwd[3], mem[8'h01]);
    end
  endtask

  task automatic test_full_pushpop();
    bit got;
    fwd.delete();
    b_din = 10'h240; b_valid = 1'b1; step(); b_valid = 1'b0;
    a_din = 10'h005; a_valid = 1'b1; step();
    a_din = 10'h155; step(); a_valid = 1'b0;
    b_din = 10'h300; b_valid = 1'b1; step(); b_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin step(); if (b_dout_valid) got = 1'b1; end
    a_din = 10'h1AA; a_valid = 1'b1; step(); a_valid = 1'b0;
    n_checks++;
    if (a_overflow !== 1'b0 || !got) begin
      n_fail++; $display("FAIL full_pushpop_ovf: a_overflow=%b read_seen=%b, expected 0 / 1", a_overflow, got);
    end
    repeat (4) step();
    n_checks++;
    if (fwd.size() != 5 || fwd[2] !== 10'h005 || fwd[3] !== 10'h155 || fwd[4] !== 10'h1AA || mem[8'h05] !== 8'hAA) begin
      n_fail++; $display("FAIL full_pushpop_order: size=%0d w=%h %h %h mem[05]=%h, expected 5 / 005 155 1aa / aa",
                         fwd.size(), fwd[2], fwd[3], fwd[4], mem[8'h05]);
    end
  endtask

  task automatic test_overflow();
    bit got;
    fwd.delete();
    b_din = 10'h212; b_valid = 1'b1; step(); b_valid = 1'b0;
    a_valid = 1'b1; a_din = 10'h003; step();
    a_din = 10'h1C3; step();
    n_checks++;
    if (a_overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_early: a_overflow=%b, expected 0", a_overflow); end
    a_din = 10'h0EE; step(); a_valid = 1'b0;
    n_checks++;
    if (a_overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: a_overflow=%b, expected 1", a_overflow); end
    b_din = 10'h300; b_valid = 1'b1; step(); b_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin step(); if (b_dout_valid) got = 1'b1; end
    repeat (5) step();
    n_checks++;
    if (!got || b_dout !== 8'hA5 || fwd.size() != 4 || fwd[2] !== 10'h003 || fwd[3] !== 10'h1C3 || mem[8'h03] !== 8'hC3 || a_overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow_drain: got=%b b_dout=%h size=%0d w=%h %h mem[03]=%h ovf=%b, expected 1 a5 4 003 1c3 c3 1",
                         got, b_dout, fwd.size(), fwd[2], fwd[3], mem[8'h03], a_overflow);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    bit seen;
    fwd.delete();
    b_din = 10'h010; b_valid = 1'b1; step(); b_valid = 1'b0;
    a_din = 10'h002; a_valid = 1'b1; step(); a_valid = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 100) begin
      step(); cyc++;
      if (lock_timeout) seen = 1'b1;
    end
    n_checks++;
    if (!seen || cyc != 64) begin
      n_fail++; $display("FAIL timeout_pulse: seen=%b after %0d cycles, expected 1 after 64", seen, cyc);
    end
    n_checks++;
    if (fwd.size() != 1) begin n_fail++; $display("FAIL timeout_hold: forwarded %0d words, expected 1", fwd.size()); end
    step();
    n_checks++;
    if (lock_timeout !== 1'b0 || ram_valid !== 1'b1 || ram_din !== 10'h002) begin
      n_fail++; $display("FAIL timeout_grant_a: lock_timeout=%b ram_valid=%b ram_din=%h, expected 0 / 1 / 002", lock_timeout, ram_valid, ram_din);
    end
    a_din = 10'h177; a_valid = 1'b1; step(); a_valid = 1'b0;
    repeat (3) step();
    n_checks++;
    if (mem[8'h02] !== 8'h77) begin n_fail++; $display("FAIL timeout_a_write: mem[02]=%h, expected 77", mem[8'h02]); end
  endtask

  task automatic test_reset_mid_read();
    int bad;
    b_din = 10'h212; b_valid = 1'b1; step();
    b_din = 10'h300; a_din = 10'h004; a_valid = 1'b1; step();
    a_valid = 1'b0;
    rst_n = 1'b0; step();
    #1;
    n_checks++;
    if ({a_dout, a_dout_valid, a_overflow, b_dout, b_dout_valid, b_ready, ram_din, ram_valid, lock_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: a_dout=%h a_dv=%b a_ovf=%b b_dout=%h b_dv=%b b_ready=%b ram_din=%h ram_valid=%b lock_timeout=%b, expected all 0",
               a_dout, a_dout_valid, a_overflow, b_dout, b_dout_valid, b_ready, ram_din, ram_valid, lock_timeout);
    end
    b_valid = 1'b0; rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      step();
      if (a_dout_valid || b_dout_valid || ram_valid) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_mid_quiet: %0d cycles with activity, expected 0", bad); end
  endtask

  task automatic test_arbitration();
    logic [9:0] exp [6];
    fwd.delete();
`ifdef ARB_RR_EN
    exp = '{10'h1A0, 10'h1B0, 10'h1A1, 10'h1B0, 10'h1A2, 10'h1B0};
`else
    exp = '{10'h1A0, 10'h1A1, 10'h1A2, 10'h1A3, 10'h1A4, 10'h1A5};
`endif
    a_din = 10'h1A0; a_valid = 1'b1; step();
    b_din = 10'h1B0; b_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      a_din = 10'h1A0 + 10'(i);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (fwd.size() <= i || fwd[i] !== exp[i]) begin
        n_fail++; $display("FAIL arbitration_grant_%0d: got %h, expected %h", i, (fwd.size() > i) ? fwd[i] : 10'h3FF, exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_b_read();
    test_lock_hold();
    test_full_pushpop();
    test_overflow();
    test_timeout();
    test_reset_mid_read();
    test_arbitration();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Shares the single-port 256x8 RAM between two requesters: the SPI-slave side (port A) and a local host/DMA side (port B).
- Both ports use the existing 10-bit RAM command word. Bits [9:8]: 00 = write-address latch, 01 = write data, 10 = read-address latch, 11 = read data. Bits [7:0] carry the address or data.
- The RAM holds one shared address latch, so the arbiter grants at transaction granularity: an address command locks the RAM to its owner until the matching data command completes.

Parameters:
- A_FIFO_DEPTH, 2: entries in the port-A command buffer (power of 2, ≥2).
- LOCK_TIMEOUT, 64: idle cycles allowed to a lock owner before forced release.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- a_din  in  10  port-A command word.
- a_valid  in  1  port-A strobe, 1 cycle per word; port A has no backpressure.
- a_dout  out  8  read data returned to port A.
- a_dout_valid  out  1  1-cycle pulse qualifying a_dout.
- a_overflow  out  1  sticky; a port-A word was dropped.
- b_din  in  10  port-B command word.
- b_valid  in  1  port-B request.
- b_ready  out  1  port-B accept; a transfer occurs when b_valid && b_ready.
- b_dout  out  8  read data returned to port B.
- b_dout_valid  out  1  1-cycle pulse qualifying b_dout.
- ram_din  out  10  command word to the RAM.
- ram_valid  out  1  1-cycle strobe qualifying ram_din.
- ram_dout  in  8  RAM read data.
- ram_dout_valid  in  1  RAM read-data strobe, 1 cycle after a read-data command.
- lock_timeout  out  1  1-cycle pulse on forced release.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE and the A FIFO empties.
  - The lock flag, expected command and timeout counter clear.
  - All outputs go to 0, including a_overflow.
  - Reset mid-transaction abandons the transaction; no read data is returned afterward.
- A FIFO:
  - Push on a_valid.
  - Push while full drops the word and sets a_overflow.
  - Push and pop in the same cycle while full is accepted, with no overflow.
- FSM states: IDLE, OWN_A, OWN_B, WAIT_RD.
- IDLE arbitration:
  - Default is fixed priority: A FIFO non-empty wins, otherwise b_valid.
  - The winner's first word is taken in the grant cycle (FIFO pop, or b_ready=1).
- Forwarding:
  - An accepted word appears on ram_din with ram_valid=1 on the next clk.
  - At most one RAM command per cycle.
- Lock rules for the accepted word's command:
  - 00 → owner state; expected next command = 01.
  - 10 → owner state; expected next command = 11.
  - 01 (expected, or orphan from IDLE) → write completes; return to IDLE.
  - 11 → WAIT_RD.
- Non-matching command while locked (e.g. 00 then 10):
  - The word is still forwarded.
  - The new command replaces the expectation, i.e. a re-address.
- WAIT_RD:
  - On ram_dout_valid, the owner's dout takes ram_dout and its dout_valid pulses 1 cycle later; then the FSM returns to IDLE.
  - ram_dout_valid outside WAIT_RD is ignored.
- b_ready:
  - 1 in IDLE when B wins arbitration.
  - 1 in OWN_B every cycle.
  - 0 otherwise, including WAIT_RD.
- Port-A words arriving while B owns the lock are buffered and never forwarded until A is granted.
- Timeout:
  - The counter runs in OWN_A, OWN_B and WAIT_RD, and clears on each accepted owner word.
  - When it reaches LOCK_TIMEOUT, the FSM goes to IDLE and lock_timeout pulses.
  - A pending read returns nothing.
- Back-to-back transactions are allowed: IDLE can grant in the cycle after release.
- Throughput: 1 command per cycle per owner.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration. A last_owner register is updated at each release; when both ports are pending in IDLE, the port other than last_owner wins. last_owner resets to B, so A wins the first tie.
- Undefined: fixed priority, A over B; B can starve while A traffic is continuous.

Test Plan:
- Port-A write: a_din 0x012, then 0x1A5 → RAM sees ram_din 0x012 then 0x1A5, each 1 cycle after its push; ram[0x12]=0xA5; back to IDLE.
- Port-B read: b_din 0x212, then 0x300, with the RAM returning 0xA5 → b_dout=0xA5 with a b_dout_valid pulse; b_ready=0 during WAIT_RD.
- Lock hold: B issues 0x240 and holds off 20 cycles while A pushes 0x001 → no port-A word reaches the RAM until B sends 0x300 and its read returns; then A's word is forwarded.
- Overflow: B holds the lock while A pushes 3 words with depth 2 → a_overflow=1; only the first 2 words are forwarded later.
- Timeout: B issues 0x010 and goes silent → lock_timeout pulses 64 cycles later; the queued A word is then granted.
- Reset mid-read: rst_n=0 during WAIT_RD → all outputs 0, FIFO empty; no dout_valid pulse occurs after reset.
- ARB_RR_EN: A and B both continuously pending → grants alternate A, B, A, B.
